// File: rtl/hps_pkg.sv
// Shared definitions for the HPS pitch detector and its frame sequencer.
//   seq_state_e        : sequencer phase (IDLE / ACCUM / ANALYZE)
//   CNT_W              : width of the detector frame counter
//   CNT_ACCUM_END      : last counter value of the accumulate phase
//   CNT_ANALYZE_START  : first counter value of the analyse phase
//   CNT_CLEAR          : counter value that clears the detector accumulators
//   DROP_W             : width of the dropped-frame counter
package hps_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        ANALYZE = 2'd2
    } seq_state_e;

    localparam int CNT_W  = 11;
    localparam int DROP_W = 16;

    localparam logic [CNT_W-1:0] CNT_ACCUM_END     = 11'd1023;
    localparam logic [CNT_W-1:0] CNT_ANALYZE_START = 11'd1024;
    localparam logic [CNT_W-1:0] CNT_CLEAR         = 11'd2047;

endpackage

// File: rtl/hps_frame_sequencer_if.sv
// FFT bin stream handshake.
//   valid : bin present            sop : first bin of an FFT frame
//   re/im : signed sample pair     ready : bin accepted when valid && ready
// master = FFT source, slave = frame sequencer.
interface hps_frame_sequencer_if #(
    parameter int DW = 16
);
    logic                 valid;
    logic                 sop;
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic                 ready;

    modport master (output valid, sop, re, im, input ready);
    modport slave  (input valid, sop, re, im, output ready);
endinterface

// File: rtl/hps_frame_sequencer_bin_power.sv
// Registered bin power stage: o_power = re^2 + im^2, one cycle after i_valid.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_valid        : a fresh bin is being accepted this cycle
//   i_re, i_im     : signed samples
//   o_valid        : o_power holds the power of a bin accepted last cycle
//   o_power        : unsigned power (held between bins, qualify with o_valid)
module bin_power #(
    parameter int DW = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic signed [DW-1:0] i_re,
    input  logic signed [DW-1:0] i_im,
    output logic                 o_valid,
    output logic [2*DW-1:0]      o_power
);

    // Each square is non-negative and at most 2^(2*DW-2), so the signed
    // products are safe and their unsigned sum fits in 2*DW bits.
    logic signed [2*DW-1:0] re_sq;
    logic signed [2*DW-1:0] im_sq;

    assign re_sq = i_re * i_re;
    assign im_sq = i_im * i_im;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_power <= '0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_power <= $unsigned(re_sq) + $unsigned(im_sq);
            end
        end
    end

endmodule

// File: rtl/hps_frame_sequencer.sv
// Frame sequencer in front of the HPS pitch detector. Accepts FFT bins,
// computes their power and drives the detector's frame counter through
// accumulate / analyse / clear so bursts, gaps and malformed frames cannot
// corrupt the detector's accumulators.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_enable       : allows a new frame to start (looked at only in IDLE)
//   bin_if         : FFT bin stream (valid/sop/re/im in, ready out)
//   o_cnt          : detector frame counter
//   o_square_add   : bin power for the detector, 0 when no fresh bin
//   o_busy         : frame in progress (ACCUM or ANALYZE)
//   o_frame_done   : one-cycle pulse as a complete frame reaches the clear count
//   o_drop_cnt     : saturating count of discarded/aborted frames
//
// state   | meaning
// IDLE    | o_cnt held at clear, ready follows i_enable, waiting for sop
// ACCUM   | one count per accepted bin, mid-frame sop aborts to IDLE
// ANALYZE | ready low, counter free-runs up to 2046, then clear + done
module hps_frame_sequencer
    import hps_pkg::*;
#(
    parameter int N_BINS = 1024,
    parameter int DW     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_enable,
    hps_frame_sequencer_if.slave bin_if,
    output logic [CNT_W-1:0]     o_cnt,
    output logic [2*DW-1:0]      o_square_add,
    output logic                 o_busy,
    output logic                 o_frame_done,
    output logic [DROP_W-1:0]    o_drop_cnt
);

    localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(N_BINS - 1);

    seq_state_e          state;
    logic                ready_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                done_q;
    logic [DROP_W-1:0]   drop_q;

    logic                accept;
    logic                pwr_load;
    logic                drop_evt;
    logic                pwr_valid;
    logic [2*DW-1:0]     pwr;

    assign accept = bin_if.valid && ready_q;

    // Only bins that become part of a frame reach the power stage; stray
    // bins in IDLE and an aborting sop never produce a detector add.
    assign pwr_load = accept && (((state == IDLE) && bin_if.sop) ||
                                 ((state == ACCUM) && !bin_if.sop));

    assign drop_evt = (bin_if.valid && bin_if.sop && !ready_q) ||
                      (accept && bin_if.sop && (state == ACCUM));

    bin_power #(.DW(DW)) u_bin_power (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (pwr_load),
        .i_re    (bin_if.re),
        .i_im    (bin_if.im),
        .o_valid (pwr_valid),
        .o_power (pwr)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            cnt_q   <= CNT_CLEAR;
            done_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (drop_evt && (drop_q != {DROP_W{1'b1}})) begin
                drop_q <= drop_q + 1'b1;
            end
            case (state)
                IDLE: begin
                    cnt_q   <= CNT_CLEAR;
                    ready_q <= i_enable;
                    if (accept && bin_if.sop) begin
                        state   <= ACCUM;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                    end
                end
                ACCUM: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        if (bin_if.sop) begin
                            state   <= IDLE;
                            cnt_q   <= CNT_CLEAR;
                            ready_q <= i_enable;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                            // ready drops with the last bin so a bin offered
                            // in the first ANALYZE cycle is never taken
                            if (cnt_q + 1'b1 == LAST_BIN) begin
                                state   <= ANALYZE;
                                ready_q <= 1'b0;
                            end
                        end
                    end
                end
                ANALYZE: begin
                    ready_q <= 1'b0;
                    if (cnt_q == CNT_CLEAR - 1'b1) begin
                        state   <= IDLE;
                        cnt_q   <= CNT_CLEAR;
                        done_q  <= 1'b1;
                        ready_q <= i_enable;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt_q   <= CNT_CLEAR;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bin_if.ready  = ready_q;
    assign o_cnt         = cnt_q;
    assign o_square_add  = pwr_valid ? pwr : '0;
    assign o_busy        = (state != IDLE);
    assign o_frame_done  = done_q;
    assign o_drop_cnt    = drop_q;

endmodule

// File: tb/tb_hps_frame_sequencer.sv
// Randomized bench for hps_frame_sequencer. A frame-level model (phase,
// bins accepted, analyse cycles elapsed) predicts every output each cycle.
module tb_hps_frame_sequencer;

    localparam int NB = 1024;
    localparam int DW = 16;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_enable;
    logic [10:0] o_cnt;
    logic [31:0] o_square_add;
    logic        o_busy;
    logic        o_frame_done;
    logic [15:0] o_drop_cnt;

    hps_frame_sequencer_if #(.DW(DW)) bin_if ();

    hps_frame_sequencer #(.N_BINS(NB), .DW(DW)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_enable     (i_enable),
        .bin_if       (bin_if),
        .o_cnt        (o_cnt),
        .o_square_add (o_square_add),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_drop_cnt   (o_drop_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_pass  = 0;
    int n_total = 0;

    // reference model: 0 idle, 1 accumulate, 2 analyse
    int     m_phase;
    int     m_k;
    int     m_a;
    int     m_drop;
    longint m_sq;
    bit     m_ready;
    bit     m_done;

    int     t_step;
    int     done_step;
    int     done_seen;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int exp_cnt();
        if (m_phase == 0) return 2047;
        if (m_phase == 1) return m_k - 1;
        return NB - 1 + m_a;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_k = 0; m_a = 0; m_drop = 0;
        m_sq = 0; m_ready = 0; m_done = 0;
    endtask

    task automatic check_outputs();
        check_val("cnt",   o_cnt,        exp_cnt());
        check_val("sq",    o_square_add, m_sq);
        check_val("ready", bin_if.ready, m_ready);
        check_val("busy",  o_busy,       m_phase != 0);
        check_val("done",  o_frame_done, m_done);
        check_val("drop",  o_drop_cnt,   m_drop);
    endtask

    // One clock: present inputs, advance model at the edge, check at negedge.
    task automatic cycle(input bit v, input bit s, input int re, input int im);
        bit     acc;
        longint p;
        bin_if.valid = v;
        bin_if.sop   = s;
        bin_if.re    = re[15:0];
        bin_if.im    = im[15:0];
        acc = v && m_ready;
        p   = longint'(re) * re + longint'(im) * im;
        @(posedge i_clk);
        m_sq = 0;
        m_done = 0;
        if (v && s && !m_ready && m_drop < 65535) m_drop++;
        case (m_phase)
            0: if (acc && s) begin m_phase = 1; m_k = 1; m_sq = p; end
            1: if (acc) begin
                   if (s) begin
                       if (m_drop < 65535) m_drop++;
                       m_phase = 0;
                   end else begin
                       m_k++;
                       m_sq = p;
                       if (m_k == NB) begin m_phase = 2; m_a = 0; end
                   end
               end
            default: begin
                if (NB - 1 + m_a == 2046) begin m_phase = 0; m_done = 1; end
                else m_a++;
            end
        endcase
        m_ready = (m_phase == 0) ? i_enable : (m_phase == 1);
        @(negedge i_clk);
        t_step++;
        check_outputs();
        if (o_frame_done) begin done_step = t_step; done_seen++; end
    endtask

    function automatic int rnd_s16();
        return int'($signed(16'($urandom)));
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    // Send n bins; first carries sop if first_sop. Random gaps of up to
    // max_gap idle cycles between bins; sop_at >= 0 puts a sop on that bin.
    task automatic send_bins(input int n, input bit first_sop, input int max_gap, input int sop_at);
        for (int i = 0; i < n; i++) begin
            if (i > 0 && max_gap > 0) idle($urandom_range(max_gap, 0));
            cycle(1, (i == 0 && first_sop) || (i == sop_at), rnd_s16(), rnd_s16());
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && m_phase != 0; i++) cycle(0, 0, 0, 0);
    endtask

    int t0;
    int d0;

    initial begin
        t_step = 0; done_step = -1; done_seen = 0;
        bin_if.valid = 0; bin_if.sop = 0; bin_if.re = 0; bin_if.im = 0;
        i_enable = 1;
        i_rst_n  = 0;
        model_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        check_outputs();
        i_rst_n = 1;
        idle(3);

        // contiguous frame, re=3 im=4
        cycle(1, 1, 3, 4);
        t0 = t_step;
        for (int i = 1; i < NB; i++) cycle(1, 0, 3, 4);
        for (int i = 0; i < 1030 && done_step < t0; i++) cycle(1, 0, 3, 4);
        check_val("frame_len", done_step - t0 + 1, 2048);
        idle(4);

        // gapped, extreme values
        cycle(1, 1, -32768, -32768);
        for (int i = 1; i < NB; i++) begin
            cycle(0, 0, 0, 0);
            cycle(1, 0, -32768, -32768);
        end
        drain();
        idle(2);

        // random gapped frame aborted by a sop at bin 500, then a clean frame
        d0 = done_seen;
        send_bins(700, 1, 2, 500);
        check_val("abort_no_done", done_seen, d0);
        idle(3);
        send_bins(NB, 1, 1, -1);
        drain();
        check_val("clean_done", done_seen, d0 + 1);

        // stray bins without sop in IDLE
        for (int i = 0; i < 20; i++) cycle($urandom_range(1, 0), 0, rnd_s16(), rnd_s16());

        // sop during ANALYZE, plus stray traffic there
        send_bins(NB, 1, 0, -1);
        for (int i = 0; i < 40; i++) cycle($urandom_range(1, 0), $urandom_range(1, 0), rnd_s16(), rnd_s16());
        drain();

        // enable low in IDLE with sop, then enable dropped mid-accumulate
        i_enable = 0;
        idle(2);
        for (int i = 0; i < 5; i++) cycle(1, 1, rnd_s16(), rnd_s16());
        i_enable = 1;
        idle(2);
        d0 = done_seen;
        send_bins(300, 1, 1, -1);
        i_enable = 0;
        send_bins(NB - 300, 0, 1, -1);
        drain();
        check_val("en_low_done", done_seen, d0 + 1);
        i_enable = 1;
        idle(3);

        // asynchronous reset mid-frame
        send_bins(200, 1, 1, -1);
        bin_if.valid = 1;
        #2 i_rst_n = 0;
        #1;
        check_val("rst_cnt",   o_cnt,        2047);
        check_val("rst_sq",    o_square_add, 0);
        check_val("rst_ready", bin_if.ready, 0);
        check_val("rst_drop",  o_drop_cnt,   0);
        check_val("rst_busy",  o_busy,       0);
        @(negedge i_clk);
        bin_if.valid = 0;
        i_rst_n = 1;
        model_reset();
        idle(2);
        send_bins(50, 0, 1, -1);
        send_bins(NB, 1, 0, -1);
        drain();

        // saturate the drop counter
        i_enable = 0;
        idle(2);
        for (int i = 0; i < 70000 && m_drop < 65535; i++) cycle(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
        check_val("drop_sat", o_drop_cnt, 65535);
        bin_if.valid = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
